// File: rtl/fetch_queue_types.sv
// Shared types and sizing for the fetch queue.
//   entry_t  : one buffered fetch result {pc, instr}
//   input_t  : every signal driven into the queue (clock and reset included)
//   output_t : every signal driven out of the queue
package fetch_queue_types;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 64;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef struct packed {
        logic               clk;
        logic               rst_n;
        logic               flush;
        logic               enq_valid;
        logic [PC_W-1:0]    enq_pc;
        logic [INSTR_W-1:0] enq_instr;
        logic               deq_ready;
    } input_t;

    typedef struct packed {
        logic               enq_ready;
        logic               deq_valid;
        logic [PC_W-1:0]    deq_pc;
        logic [INSTR_W-1:0] deq_instr;
        logic [CNT_W-1:0]   count;
    } output_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {pc, instr}
// with valid/ready handshakes on both sides and a synchronous flush.
// Ports:
//   fetch_queue_input  : clk, rst_n (async, active-low), flush, enq_valid,
//                        enq_pc, enq_instr, deq_ready
//   fetch_queue_output : enq_ready, deq_valid, deq_pc, deq_instr, count
// No bypass: an entry written at an edge appears on deq_* only after that edge.
module fetch_queue
    import fetch_queue_types::*;
(
    input  input_t  fetch_queue_input,
    output output_t fetch_queue_output
);

    logic clk;
    logic rst_n;
    logic flush;

    assign clk   = fetch_queue_input.clk;
    assign rst_n = fetch_queue_input.rst_n;
    assign flush = fetch_queue_input.flush;

    entry_t             storage_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    logic               full;
    logic               empty;
    logic               enq_fire;
    logic               deq_fire;
    entry_t             enq_entry;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    // Ready/valid depend only on registered occupancy, never on the other side.
    assign enq_fire  = fetch_queue_input.enq_valid & ~full;
    assign deq_fire  = fetch_queue_input.deq_ready & ~empty;
    assign enq_entry = '{pc: fetch_queue_input.enq_pc, instr: fetch_queue_input.enq_instr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
        end else if (flush) begin
            // Same-cycle enqueue is dropped and dequeue has no effect; storage keeps stale data.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                storage_q[tail_q] <= enq_entry;
                tail_q            <= tail_q + PTR_W'(1);
            end
            if (deq_fire) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        fetch_queue_output           = '0;
        fetch_queue_output.enq_ready = ~full;
        fetch_queue_output.deq_valid = ~empty;
        fetch_queue_output.deq_pc    = storage_q[head_q].pc;
        fetch_queue_output.deq_instr = storage_q[head_q].instr;
        fetch_queue_output.count     = count_q;
    end

`ifndef SYNTHESIS
    a_no_enq_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(enq_fire && full));

    a_no_deq_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
        !(deq_fire && empty));

    // Pointer distance matches occupancy; equal pointers mean empty or full.
    a_count_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
        (PTR_W'(tail_q - head_q) == count_q[PTR_W-1:0]) && (count_q <= CNT_W'(DEPTH)) &&
        ((tail_q != head_q) || empty || full));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_queue_types::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               enq_valid;
    logic [PC_W-1:0]    enq_pc;
    logic [INSTR_W-1:0] enq_instr;
    logic               deq_ready;

    input_t  in_s;
    output_t out_s;

    assign in_s = '{clk: clk, rst_n: rst_n, flush: flush, enq_valid: enq_valid,
                    enq_pc: enq_pc, enq_instr: enq_instr, deq_ready: deq_ready};

    fetch_queue dut (
        .fetch_queue_input  (in_s),
        .fetch_queue_output (out_s)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    entry_t exp_q[$];
    int     mcount = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model's view of the queue.
    task automatic check_outputs(input string tag);
        chk({tag, ":deq_valid"}, 64'(out_s.deq_valid), 64'(mcount != 0));
        chk({tag, ":enq_ready"}, 64'(out_s.enq_ready), 64'(mcount != DEPTH));
        chk({tag, ":count"}, 64'(out_s.count), 64'(mcount));
        if (mcount != 0) begin
            chk({tag, ":head_pc"}, out_s.deq_pc, exp_q[0].pc);
            chk({tag, ":head_instr"}, out_s.deq_instr, exp_q[0].instr);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, consume a popped entry, clock, update model.
    task automatic cycle(input string tag, input logic fl, input logic ev,
                         input logic [PC_W-1:0] pc, input logic dr);
        logic   ef;
        logic   df;
        entry_t popped;
        flush     = fl;
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = {~pc[31:0], pc[31:0] ^ 32'h5a5a_0f0f};
        deq_ready = dr;
        #1;
        check_outputs(tag);
        ef = ev && (mcount != DEPTH) && !fl;
        df = dr && (mcount != 0) && !fl;
        if (df) begin
            popped = exp_q.pop_front();
            chk({tag, ":pop_pc"}, out_s.deq_pc, popped.pc);
            chk({tag, ":pop_instr"}, out_s.deq_instr, popped.instr);
        end
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (ef) begin
                exp_q.push_back('{pc: pc, instr: {~pc[31:0], pc[31:0] ^ 32'h5a5a_0f0f}});
            end
            mcount = exp_q.size();
        end
    endtask

    initial begin
        // T1 reset with enq_valid held high
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b1;
        enq_pc    = 64'h1234;
        enq_instr = 64'hffff_0000_ffff_0000;
        deq_ready = 1'b1;
        #12;
        chk("rst:deq_valid", 64'(out_s.deq_valid), 64'd0);
        chk("rst:enq_ready", 64'(out_s.enq_ready), 64'd1);
        chk("rst:count", 64'(out_s.count), 64'd0);
        chk("rst:deq_instr", out_s.deq_instr, 64'd0);
        chk("rst:deq_pc", out_s.deq_pc, 64'd0);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // T2 single pass, then observe directly
        flush     = 1'b0;
        enq_valid = 1'b1;
        enq_pc    = 64'h1000;
        enq_instr = 64'hdead_beef_dead_beef;
        deq_ready = 1'b0;
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        chk("t2:deq_valid", 64'(out_s.deq_valid), 64'd1);
        chk("t2:deq_pc", out_s.deq_pc, 64'h1000);
        chk("t2:deq_instr", out_s.deq_instr, 64'hdead_beef_dead_beef);
        chk("t2:count", 64'(out_s.count), 64'd1);
        exp_q.push_back('{pc: 64'h1000, instr: 64'hdead_beef_dead_beef});
        mcount = 1;
        cycle("t2drain", 1'b0, 1'b0, '0, 1'b1);

        // T3 fill past full with decode stalled, then drain
        for (int i = 0; i < 5; i++) cycle("t3fill", 1'b0, 1'b1, 64'(i * 8), 1'b0);
        cycle("t3hold", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("t3drain", 1'b0, 1'b0, '0, 1'b1);

        // T4 simultaneous enqueue/dequeue at count=2, then at full
        cycle("t4a", 1'b0, 1'b1, 64'h100, 1'b0);
        cycle("t4a", 1'b0, 1'b1, 64'h108, 1'b0);
        for (int i = 0; i < 3; i++) cycle("t4both", 1'b0, 1'b1, 64'h110 + 64'(i * 8), 1'b1);
        cycle("t4fill", 1'b0, 1'b1, 64'h200, 1'b0);
        cycle("t4fill", 1'b0, 1'b1, 64'h208, 1'b0);
        cycle("t4full", 1'b0, 1'b1, 64'h210, 1'b1);
        for (int i = 0; i < 4; i++) cycle("t4drain", 1'b0, 1'b0, '0, 1'b1);

        // T5 streaming across pointer wrap
        for (int i = 0; i < 10; i++) cycle("t5", 1'b0, 1'b1, 64'h300 + 64'(i * 4), 1'b1);
        cycle("t5end", 1'b0, 1'b0, '0, 1'b1);
        cycle("t5empty", 1'b0, 1'b0, '0, 1'b1);

        // T6 flush at count=3 with a same-cycle enqueue and dequeue
        for (int i = 0; i < 3; i++) cycle("t6fill", 1'b0, 1'b1, 64'h20 + 64'(i * 8), 1'b0);
        cycle("t6flush", 1'b1, 1'b1, 64'h40, 1'b1);
        cycle("t6after", 1'b0, 1'b1, 64'h80, 1'b0);
        cycle("t6seen", 1'b0, 1'b0, '0, 1'b1);
        cycle("t6empty", 1'b0, 1'b0, '0, 1'b0);

        // Asynchronous reset in the middle of operation
        cycle("arst", 1'b0, 1'b1, 64'h500, 1'b0);
        cycle("arst", 1'b0, 1'b1, 64'h508, 1'b0);
        enq_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("arst:count", 64'(out_s.count), 64'd0);
        chk("arst:deq_valid", 64'(out_s.deq_valid), 64'd0);
        chk("arst:enq_ready", 64'(out_s.enq_ready), 64'd1);
        chk("arst:deq_pc", out_s.deq_pc, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        mcount = 0;
        cycle("post", 1'b0, 1'b1, 64'h600, 1'b0);
        cycle("post", 1'b0, 1'b0, '0, 1'b1);
        cycle("post", 1'b0, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
